hazard_stall_controller: RTL and testbench

Sequencing controller for the ID-stage hazard logic of the 5-stage MIPS pipeline. Each cycle it decides whether the instruction in ID may advance, must be held for one or two cycles (load-use, branch-after-ALU, branch-after-load), or whether IF/ID must be flushed after a taken branch or jump. It owns a stall down-counter, so a multi-cycle stall commits once and is not re-evaluated mid-sequence. It drives PC/IF-ID write enables and the ID/EX bubble; the ID branch comparator's forwarding selects are computed elsewhere.

---
 rtl/mips_hazard_pkg.sv | 14 +
 rtl/hazard_match.sv | 14 +
 rtl/hazard_stall_controller.sv | 121 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// Shared types and stall-length constants for the ID-stage hazard controller.
package mips_hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [1:0] STALL_BR_LOAD    = 2'd2;
    localparam logic [1:0] STALL_BR_ALU     = 2'd1;
    localparam logic [1:0] STALL_BR_MEMLOAD = 2'd1;
    localparam logic [1:0] STALL_LOAD_USE   = 2'd1;

endpackage

// File: rtl/hazard_match.sv
// Compares one producer destination against the ID instruction's source registers.
module hazard_match (
    input  logic [4:0] dest_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rt_i,
    output logic       match_o
);

    // $zero is never a real producer, so it can never create a hazard.
    assign match_o = (dest_i != 5'd0) &&
                     ((rs_i == dest_i) || (uses_rt_i && (rt_i == dest_i)));

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage stall/flush sequencer: commits a 1- or 2-cycle stall once and counts it down.
module hazard_stall_controller
    import mips_hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_stall,
    input  logic [4:0]             Rs_id,
    input  logic [4:0]             Rt_id,
    input  logic                   UsesRt_id,
    input  logic                   Branch_id,
    input  logic                   Jump_id,
    input  logic                   BranchTaken_id,
    input  logic                   RegWrite_ex,
    input  logic                   MemRead_ex,
    input  logic [4:0]             writeRegOut_ex,
    input  logic                   MemRead_mem,
    input  logic [4:0]             writeRegOut_mem,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IDEX_Bubble,
    output logic                   IF_Flush,
    output logic                   pipe_freeze,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   m_ex;
    logic                   m_mem;
    logic [1:0]             need;
    logic                   stall_now;
    state_e                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    hazard_match u_match_ex (
        .dest_i    (writeRegOut_ex),
        .rs_i      (Rs_id),
        .rt_i      (Rt_id),
        .uses_rt_i (UsesRt_id),
        .match_o   (m_ex)
    );

    hazard_match u_match_mem (
        .dest_i    (writeRegOut_mem),
        .rs_i      (Rs_id),
        .rt_i      (Rt_id),
        .uses_rt_i (UsesRt_id),
        .match_o   (m_mem)
    );

    always_comb begin
        need = 2'd0;
        if (Branch_id && MemRead_ex && m_ex)
            need = STALL_BR_LOAD;
        else if (Branch_id && RegWrite_ex && m_ex)
            need = STALL_BR_ALU;
        else if (Branch_id && MemRead_mem && m_mem)
            need = STALL_BR_MEMLOAD;
        else if (MemRead_ex && m_ex)
            need = STALL_LOAD_USE;
    end

    // In HOLD the committed sequence runs out regardless of what ID now shows.
    assign stall_now = !ext_stall && ((state_q == HOLD) || (need != 2'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;
        if (!ext_stall) begin
            if (state_q == HOLD)
                cnt_d = cnt_q - 2'd1;
            else if (need != 2'd0)
                cnt_d = need - 2'd1;
            state_d = (cnt_d == 2'd0) ? RUN : HOLD;
        end
        if (stall_now && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IF_Flush    = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            IF_Flush    = 1'b1;
        end else if (ext_stall) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            pipe_freeze = 1'b1;
        end else if (stall_now) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            IF_Flush = Jump_id || (Branch_id && BranchTaken_id);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: a cycle model predicts each cycle's outputs, queued and checked mid-cycle.
module tb_hazard_stall_controller;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, ext_stall, UsesRt_id, Branch_id, Jump_id, BranchTaken_id;
    logic         RegWrite_ex, MemRead_ex, MemRead_mem;
    logic [4:0]   Rs_id, Rt_id, writeRegOut_ex, writeRegOut_mem;
    logic         PCWrite, IFIDWrite, IDEX_Bubble, IF_Flush, pipe_freeze;
    logic [W-1:0] stall_cycles;

    typedef struct {
        logic       rst, ext, uses, br, jmp, tk, rw_ex, mr_ex, mr_mem;
        logic [4:0] rs, rt, wr_ex, wr_mem;
    } in_t;

    typedef struct {
        logic pcw, ifw, bub, flush, frz;
        int   sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    int   m_sc    = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.STALL_CNT_W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ext_stall       (ext_stall),
        .Rs_id           (Rs_id),
        .Rt_id           (Rt_id),
        .UsesRt_id       (UsesRt_id),
        .Branch_id       (Branch_id),
        .Jump_id         (Jump_id),
        .BranchTaken_id  (BranchTaken_id),
        .RegWrite_ex     (RegWrite_ex),
        .MemRead_ex      (MemRead_ex),
        .writeRegOut_ex  (writeRegOut_ex),
        .MemRead_mem     (MemRead_mem),
        .writeRegOut_mem (writeRegOut_mem),
        .PCWrite         (PCWrite),
        .IFIDWrite       (IFIDWrite),
        .IDEX_Bubble     (IDEX_Bubble),
        .IF_Flush        (IF_Flush),
        .pipe_freeze     (pipe_freeze),
        .stall_cycles    (stall_cycles)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s = '{rst: 1'b0, ext: 1'b0, uses: 1'b0, br: 1'b0, jmp: 1'b0, tk: 1'b0,
              rw_ex: 1'b0, mr_ex: 1'b0, mr_mem: 1'b0,
              rs: 5'd0, rt: 5'd0, wr_ex: 5'd0, wr_mem: 5'd0};
        return s;
    endfunction

    function automatic bit mt(input logic [4:0] d, input in_t s);
        if (d == 5'd0) return 1'b0;
        return (s.rs == d) || (s.uses && s.rt == d);
    endfunction

    function automatic int need_of(input in_t s);
        bit mex, mmem;
        mex  = mt(s.wr_ex, s);
        mmem = mt(s.wr_mem, s);
        if (s.br && s.mr_ex && mex)   return 2;
        if (s.br && s.rw_ex && mex)   return 1;
        if (s.br && s.mr_mem && mmem) return 1;
        if (s.mr_ex && mex)           return 1;
        return 0;
    endfunction

    // Drive one cycle of stimulus, predict the outputs, then check them mid-cycle.
    task automatic step(input in_t s);
        exp_t e, g;
        int   n;
        reset = s.rst; ext_stall = s.ext; Rs_id = s.rs; Rt_id = s.rt;
        UsesRt_id = s.uses; Branch_id = s.br; Jump_id = s.jmp; BranchTaken_id = s.tk;
        RegWrite_ex = s.rw_ex; MemRead_ex = s.mr_ex; writeRegOut_ex = s.wr_ex;
        MemRead_mem = s.mr_mem; writeRegOut_mem = s.wr_mem;
        e.sc = m_sc;
        if (s.rst) begin
            e.pcw = 0; e.ifw = 0; e.bub = 1; e.flush = 1; e.frz = 0;
            m_cnt = 0; m_sc = 0;
        end else if (s.ext) begin
            e.pcw = 0; e.ifw = 0; e.bub = 0; e.flush = 0; e.frz = 1;
        end else begin
            n = need_of(s);
            if (m_cnt > 0 || n > 0) begin
                e.pcw = 0; e.ifw = 0; e.bub = 1; e.flush = 0; e.frz = 0;
                m_cnt = (m_cnt > 0) ? m_cnt - 1 : n - 1;
                if (m_sc < (1 << W) - 1) m_sc++;
            end else begin
                e.pcw = 1; e.ifw = 1; e.bub = 0; e.frz = 0;
                e.flush = s.jmp || (s.br && s.tk);
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk("PCWrite",      int'(PCWrite),      int'(g.pcw));
        chk("IFIDWrite",    int'(IFIDWrite),    int'(g.ifw));
        chk("IDEX_Bubble",  int'(IDEX_Bubble),  int'(g.bub));
        chk("IF_Flush",     int'(IF_Flush),     int'(g.flush));
        chk("pipe_freeze",  int'(pipe_freeze),  int'(g.frz));
        chk("stall_cycles", int'(stall_cycles), g.sc);
        @(posedge clk);
        #1;
    endtask

    in_t s, rst_s, lu, bl, ba;

    initial begin
        rst_s = idle(); rst_s.rst = 1'b1;
        // lw $t0 in EX, add using $t0 in ID
        lu = idle(); lu.mr_ex = 1; lu.rw_ex = 1; lu.wr_ex = 5'd8; lu.rs = 5'd8; lu.uses = 1;
        // lw $t0 in EX, beq $t0,$t1 in ID
        bl = idle(); bl.br = 1; bl.mr_ex = 1; bl.rw_ex = 1; bl.wr_ex = 5'd8;
        bl.rs = 5'd8; bl.rt = 5'd9; bl.uses = 1;
        // add $t2 in EX, bne $t2,$zero in ID
        ba = idle(); ba.br = 1; ba.rw_ex = 1; ba.wr_ex = 5'd10; ba.rs = 5'd10; ba.uses = 1;

        @(posedge clk); #1;
        step(rst_s);
        step(rst_s);
        chk("rst_sc", int'(stall_cycles), 0);

        step(lu);
        s = idle(); s.rs = 5'd8; s.uses = 1; s.mr_mem = 1; s.wr_mem = 5'd8;
        step(s);
        chk("lu_sc", int'(stall_cycles), 1);

        step(bl);
        s = idle(); s.br = 1; s.rs = 5'd8; s.rt = 5'd9; s.uses = 1; s.mr_mem = 1; s.wr_mem = 5'd8;
        step(s);
        s = idle(); s.br = 1; s.rs = 5'd8; s.rt = 5'd9; s.uses = 1;
        step(s);
        chk("bl_sc", int'(stall_cycles), 3);

        step(ba);
        s = idle(); s.br = 1; s.tk = 1; s.rs = 5'd10; s.uses = 1; s.rw_ex = 0; s.wr_mem = 5'd10;
        step(s);
        step(idle());

        s = idle(); s.mr_ex = 1; s.rw_ex = 1; s.wr_ex = 5'd0; s.rs = 5'd0;
        step(s);

        s = idle(); s.jmp = 1;
        step(s);

        // Freeze during the HOLD cycle; one stall cycle must remain afterwards.
        step(bl);
        s = bl; s.ext = 1;
        for (int i = 0; i < 3; i++) step(s);
        step(bl);
        step(idle());

        // Reset in HOLD, then a clean cycle with no hazard.
        step(bl);
        step(rst_s);
        step(idle());
        chk("rst_hold_sc", int'(stall_cycles), 0);

        for (int i = 0; i < 20; i++) step(lu);
        chk("sat_sc", int'(stall_cycles), (1 << W) - 1);
        step(rst_s);

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst    = ($urandom_range(0, 49) == 0);
            s.ext    = ($urandom_range(0, 7) == 0);
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.uses   = 1'($urandom_range(0, 1));
            s.br     = 1'($urandom_range(0, 1));
            s.jmp    = !s.br && ($urandom_range(0, 5) == 0);
            s.tk     = 1'($urandom_range(0, 1));
            s.rw_ex  = 1'($urandom_range(0, 1));
            s.mr_ex  = s.rw_ex && ($urandom_range(0, 1) == 1);
            s.wr_ex  = 5'($urandom_range(0, 3));
            s.mr_mem = 1'($urandom_range(0, 1));
            s.wr_mem = 5'($urandom_range(0, 3));
            step(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
